// File: rtl/acc_stack.sv
// Accumulator with in-place shifts, carry flag and a LIFO shadow stack for save/restore.
// Define ACC_ROTATE_EN to make SHL/SHR rotate through carry instead of shifting in carry_in.
module acc_stack #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       enable,
   input  logic [2:0]                 op,
   input  logic [WIDTH-1:0]           A_in,
   input  logic                       carry_in,
   output logic [WIDTH-1:0]           A_out,
   output logic                       zero,
   output logic                       carry_out,
   output logic [$clog2(DEPTH+1)-1:0] stk_count,
   output logic                       stk_full,
   output logic                       stk_empty,
   output logic                       stk_err
);

   localparam int unsigned CW    = $clog2(DEPTH + 1);
   localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned NSLOT = 1 << AW;

   typedef enum logic [2:0] {
      OP_HOLD  = 3'd0,
      OP_LOAD  = 3'd1,
      OP_CLEAR = 3'd2,
      OP_SHL   = 3'd3,
      OP_SHR   = 3'd4,
      OP_PUSH  = 3'd5,
      OP_POP   = 3'd6,
      OP_SWAP  = 3'd7
   } op_e;

   op_e              op_c;
   logic [WIDTH-1:0] acc_q, acc_n;
   logic             carry_q, carry_n;
   logic [CW-1:0]    count_q, count_n;
   logic             err_q, err_n;
   logic [WIDTH-1:0] stack [NSLOT];
   logic             stk_we;
   logic [AW-1:0]    wr_idx;
   logic [AW-1:0]    top_idx;
   logic [CW-1:0]    count_m1;
   logic             shift_bit;
   logic             is_full, is_empty;

   assign op_c     = op_e'(op);
   assign is_full  = (count_q == CW'(DEPTH));
   assign is_empty = (count_q == '0);
   assign count_m1 = count_q - CW'(1);
   assign top_idx  = count_m1[AW-1:0];

`ifdef ACC_ROTATE_EN
   logic unused_carry_in;
   assign unused_carry_in = carry_in;
   assign shift_bit       = carry_q;
`else
   assign shift_bit = carry_in;
`endif

   always_comb begin
      acc_n   = acc_q;
      carry_n = carry_q;
      count_n = count_q;
      err_n   = err_q;
      stk_we  = 1'b0;
      wr_idx  = count_q[AW-1:0];
      if (enable) begin
         case (op_c)
            OP_LOAD:  acc_n = A_in;
            OP_CLEAR: acc_n = '0;
            OP_SHL: begin
               acc_n   = {acc_q[WIDTH-2:0], shift_bit};
               carry_n = acc_q[WIDTH-1];
            end
            OP_SHR: begin
               acc_n   = {shift_bit, acc_q[WIDTH-1:1]};
               carry_n = acc_q[0];
            end
            OP_PUSH: begin
               if (is_full) begin
                  err_n = 1'b1;
               end else begin
                  stk_we  = 1'b1;
                  acc_n   = A_in;
                  count_n = count_q + CW'(1);
               end
            end
            OP_POP: begin
               if (is_empty) begin
                  err_n = 1'b1;
               end else begin
                  acc_n   = stack[top_idx];
                  count_n = count_m1;
               end
            end
            OP_SWAP: begin
               // old top comes out while old accumulator goes into the same slot
               if (is_empty) begin
                  err_n = 1'b1;
               end else begin
                  acc_n  = stack[top_idx];
                  stk_we = 1'b1;
                  wr_idx = top_idx;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q   <= '0;
         carry_q <= 1'b0;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         acc_q   <= acc_n;
         carry_q <= carry_n;
         count_q <= count_n;
         err_q   <= err_n;
      end
   end

   // Stack contents need no reset: an entry is always written before it can be read.
   always_ff @(posedge clk) begin
      if (!reset && stk_we) stack[wr_idx] <= acc_q;
   end

   assign A_out     = acc_q;
   assign carry_out = carry_q;
   assign stk_count = count_q;
   assign stk_err   = err_q;
   assign zero      = (acc_q == '0);
   assign stk_full  = is_full;
   assign stk_empty = is_empty;

endmodule

// File: tb/tb_acc_stack.sv
// Self-checking bench for acc_stack: behavioural model feeds a scoreboard queue of expected states.
// Build with ACC_ROTATE_EN defined to exercise the rotate-through-carry shifts.
module tb_acc_stack;

   localparam int unsigned WIDTH = 4;
   localparam int unsigned DEPTH = 4;

   logic       clk = 1'b0;
   logic       reset, enable, carry_in;
   logic [2:0] op;
   logic [3:0] A_in;
   logic [3:0] A_out;
   logic       zero, carry_out, stk_full, stk_empty, stk_err;
   logic [2:0] stk_count;

   acc_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .enable(enable), .op(op), .A_in(A_in),
      .carry_in(carry_in), .A_out(A_out), .zero(zero), .carry_out(carry_out),
      .stk_count(stk_count), .stk_full(stk_full), .stk_empty(stk_empty),
      .stk_err(stk_err)
   );

   always #5 clk = ~clk;

   // {A_out, carry_out, stk_count, stk_err, zero, stk_full, stk_empty}
   logic [11:0] sb[$];
   int          checks = 0;
   int          errors = 0;

   logic [3:0] m_a;
   logic       m_c, m_err;
   int         m_cnt;
   logic [3:0] m_stk [DEPTH];

   function automatic logic [11:0] observed();
      return {A_out, carry_out, stk_count, stk_err, zero, stk_full, stk_empty};
   endfunction

   // Drives one cycle, advances the model and queues the expected post-edge state.
   task automatic drive(input logic rst, input logic en, input logic [2:0] o,
                        input logic [3:0] a, input logic cin);
      logic       nb;
      logic [3:0] t;
      reset = rst; enable = en; op = o; A_in = a; carry_in = cin;
`ifdef ACC_ROTATE_EN
      nb = m_c;
`else
      nb = cin;
`endif
      if (rst) begin
         m_a = 4'd0; m_c = 1'b0; m_cnt = 0; m_err = 1'b0;
      end else if (en) begin
         case (o)
            3'd1: m_a = a;
            3'd2: m_a = 4'd0;
            3'd3: begin m_c = m_a[3]; m_a = {m_a[2:0], nb}; end
            3'd4: begin m_c = m_a[0]; m_a = {nb, m_a[3:1]}; end
            3'd5: if (m_cnt == DEPTH) m_err = 1'b1;
                  else begin m_stk[m_cnt] = m_a; m_a = a; m_cnt++; end
            3'd6: if (m_cnt == 0) m_err = 1'b1;
                  else begin m_cnt--; m_a = m_stk[m_cnt]; end
            3'd7: if (m_cnt == 0) m_err = 1'b1;
                  else begin t = m_stk[m_cnt-1]; m_stk[m_cnt-1] = m_a; m_a = t; end
            default: ;
         endcase
      end
      sb.push_back({m_a, m_c, 3'(m_cnt), m_err, (m_a == 4'd0), (m_cnt == DEPTH), (m_cnt == 0)});
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [11:0] e;
      drive(1'b1, 1'b0, 3'd0, 4'd0, 1'b0);
      e = sb.pop_front();
      checks++;
      if (observed() !== e || e !== 12'b0000_0_000_0_1_0_1) begin
         errors++; $display("FAIL reset state got %h want %h", observed(), 12'b0000_0_000_0_1_0_1);
      end
      drive(1'b0, 1'b0, 3'd1, 4'd9, 1'b0);
      e = sb.pop_front();
      checks++;
      if (observed() !== e || A_out !== 4'd0) begin
         errors++; $display("FAIL idle_disabled got %h want %h", observed(), e);
      end
   endtask

   task automatic test_shift();
      logic [11:0] e;
      logic [3:0]  want_a [3];
      logic        want_c [3];
      logic [2:0]  ops [3];
      logic        cins [3];
      logic [3:0]  ins [3];
`ifdef ACC_ROTATE_EN
      ops = '{3'd1, 3'd3, 3'd3}; ins = '{4'b1000, 4'd0, 4'd0}; cins = '{1'b1, 1'b1, 1'b0};
      want_a = '{4'b1000, 4'b0000, 4'b0001}; want_c = '{1'b0, 1'b1, 1'b0};
`else
      ops = '{3'd1, 3'd3, 3'd4}; ins = '{4'b1011, 4'd0, 4'd0}; cins = '{1'b0, 1'b0, 1'b1};
      want_a = '{4'b1011, 4'b0110, 4'b1011}; want_c = '{1'b0, 1'b1, 1'b0};
`endif
      drive(1'b1, 1'b0, 3'd0, 4'd0, 1'b0);
      void'(sb.pop_front());
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, ops[i], ins[i], cins[i]);
         e = sb.pop_front();
         checks++;
         if (observed() !== e || A_out !== want_a[i] || carry_out !== want_c[i]) begin
            errors++; $display("FAIL shift step %0d got A=%b c=%b (%h) want A=%b c=%b (%h)",
                               i, A_out, carry_out, observed(), want_a[i], want_c[i], e);
         end
      end
   endtask

   task automatic test_stack_full();
      logic [11:0] e;
      logic [2:0]  ops [10] = '{3'd1, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd6, 3'd6, 3'd6, 3'd6};
      logic [3:0]  ins [10] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd0, 4'd0, 4'd0, 4'd0};
      logic [3:0]  wa  [10] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
      logic [2:0]  wn  [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
      drive(1'b1, 1'b0, 3'd0, 4'd0, 1'b0);
      void'(sb.pop_front());
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 1'b1, ops[i], ins[i], 1'b0);
         e = sb.pop_front();
         checks++;
         if (observed() !== e || A_out !== wa[i] || stk_count !== wn[i] || stk_err !== (i >= 5)) begin
            errors++; $display("FAIL stack_full step %0d got %h want %h (A=%0d cnt=%0d)",
                               i, observed(), e, wa[i], wn[i]);
         end
      end
   endtask

   task automatic test_empty_misuse();
      logic [11:0] e;
      logic [2:0]  ops [6] = '{3'd1, 3'd6, 3'd7, 3'd5, 3'd7, 3'd6};
      logic [3:0]  ins [6] = '{4'd3, 4'd0, 4'd0, 4'd6, 4'd0, 4'd0};
      logic [3:0]  wa  [6] = '{4'd3, 4'd3, 4'd3, 4'd6, 4'd3, 4'd6};
      drive(1'b1, 1'b0, 3'd0, 4'd0, 1'b0);
      void'(sb.pop_front());
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, 1'b1, ops[i], ins[i], 1'b0);
         e = sb.pop_front();
         checks++;
         if (observed() !== e || A_out !== wa[i] || stk_err !== (i >= 1)) begin
            errors++; $display("FAIL empty_misuse step %0d got %h want %h", i, observed(), e);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [11:0] e;
      drive(1'b1, 1'b0, 3'd0, 4'd0, 1'b0);
      drive(1'b0, 1'b1, 3'd5, 4'd1, 1'b0);
      drive(1'b0, 1'b1, 3'd5, 4'd2, 1'b0);
      drive(1'b0, 1'b1, 3'd6, 4'd0, 1'b0);
      drive(1'b0, 1'b1, 3'd6, 4'd0, 1'b0);
      drive(1'b0, 1'b1, 3'd6, 4'd0, 1'b0);
      drive(1'b0, 1'b1, 3'd5, 4'd8, 1'b0);
      drive(1'b0, 1'b1, 3'd5, 4'd9, 1'b0);
      for (int i = 0; i < 8; i++) void'(sb.pop_front());
      checks++;
      if (stk_count !== 3'd2 || stk_err !== 1'b1) begin
         errors++; $display("FAIL reset_mid setup got cnt=%0d err=%b want cnt=2 err=1", stk_count, stk_err);
      end
      drive(1'b1, 1'b1, 3'd5, 4'd9, 1'b0);
      e = sb.pop_front();
      checks++;
      if (observed() !== e || stk_count !== 3'd0 || A_out !== 4'd0 || stk_err !== 1'b0) begin
         errors++; $display("FAIL reset_mid got %h want %h", observed(), e);
      end
   endtask

   task automatic test_back_to_back();
      logic [11:0] e;
      drive(1'b1, 1'b0, 3'd0, 4'd0, 1'b0);
      void'(sb.pop_front());
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) != 0), 3'($urandom_range(0, 7)),
               4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
         if (sb.size() == 0) begin
            errors++; checks++; $display("FAIL back_to_back scoreboard empty got 0 want 1 entry");
         end else begin
            e = sb.pop_front();
            checks++;
            if (observed() !== e) begin
               errors++; $display("FAIL back_to_back cycle %0d got %h want %h", i, observed(), e);
            end
         end
      end
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; op = 3'd0; A_in = 4'd0; carry_in = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_shift();
      test_stack_full();
      test_empty_misuse();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
